// File: rtl/tick_div_prog.sv
// Programmable tick/clock divider: one-cycle TICK_OUT every DIV cycles and a
// 50%-duty CLK_OUT of period 2*DIV, with one-shot mode and expiry-aligned reload.
module tick_div_prog #(
    parameter int          NBIT        = 16,
    parameter int unsigned DEFAULT_DIV = 25000
) (
    input  logic            CLOCK_IN,
    input  logic            RESET_N,
    input  logic            EN,
    input  logic            ONESHOT,
    input  logic            DIV_LOAD,
    input  logic [NBIT-1:0] DIV_IN,
    output logic            CLK_OUT,
    output logic            TICK_OUT,
    output logic            DONE,
    output logic            DIV_ERR,
    output logic [NBIT-1:0] COUNT_OUT
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [NBIT-1:0] ONE     = NBIT'(1);
    localparam logic [NBIT-1:0] DEF_DIV = NBIT'(DEFAULT_DIV);

    logic [1:0]      state;
    logic [NBIT-1:0] div;
    logic [NBIT-1:0] pend;
    logic            pend_valid;
    logic [NBIT-1:0] count;
    logic            clk_q;
    logic            tick_q;
    logic            err_q;

    logic            load_ok;
    logic [NBIT-1:0] newdiv;

    // A same-cycle load beats an older pending value, which beats the active divisor.
    always_comb begin
        load_ok = DIV_LOAD && (DIV_IN != '0);
        newdiv  = div;
        if (load_ok)
            newdiv = DIV_IN;
        else if (pend_valid)
            newdiv = pend;
    end

    always_ff @(posedge CLOCK_IN) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            div        <= DEF_DIV;
            pend       <= '0;
            pend_valid <= 1'b0;
            count      <= DEF_DIV - ONE;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (DIV_LOAD && (DIV_IN == '0))
                err_q <= 1'b1;

            case (state)
                S_IDLE: begin
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (load_ok) begin
                        div   <= DIV_IN;
                        count <= DIV_IN - ONE;
                    end
                    if (EN)
                        state <= S_RUN;
                end

                S_RUN: begin
                    if (!EN) begin
                        state      <= S_IDLE;
                        div        <= newdiv;
                        count      <= newdiv - ONE;
                        pend_valid <= 1'b0;
                        clk_q      <= 1'b0;
                        tick_q     <= 1'b0;
                    end else if (count != '0) begin
                        count  <= count - ONE;
                        tick_q <= 1'b0;
                        // Mid-period loads wait in the shadow until expiry.
                        if (load_ok) begin
                            pend       <= DIV_IN;
                            pend_valid <= 1'b1;
                        end
                    end else begin
                        tick_q     <= 1'b1;
                        clk_q      <= ~clk_q;
                        div        <= newdiv;
                        count      <= newdiv - ONE;
                        pend_valid <= 1'b0;
                        if (ONESHOT)
                            state <= S_DONE;
                    end
                end

                S_DONE: begin
                    tick_q <= 1'b0;
                    if (load_ok) begin
                        div   <= DIV_IN;
                        count <= DIV_IN - ONE;
                    end
                    if (!EN) begin
                        state <= S_IDLE;
                        clk_q <= 1'b0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign CLK_OUT   = clk_q;
    assign TICK_OUT  = tick_q;
    assign DONE      = (state == S_DONE);
    assign DIV_ERR   = err_q;
    assign COUNT_OUT = count;

endmodule

// File: tb/tb_tick_div_prog.sv
// Bench for tick_div_prog: period-level reference model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_tick_div_prog;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        oneshot;
    logic        div_load;
    logic [15:0] div_in;
    logic        clk_out;
    logic        tick_out;
    logic        done;
    logic        div_err;
    logic [15:0] count_out;

    int n_chk  = 0;
    int n_fail = 0;

    tick_div_prog #(.NBIT(16), .DEFAULT_DIV(25000)) dut (
        .CLOCK_IN (clk),
        .RESET_N  (rst_n),
        .EN       (en),
        .ONESHOT  (oneshot),
        .DIV_LOAD (div_load),
        .DIV_IN   (div_in),
        .CLK_OUT  (clk_out),
        .TICK_OUT (tick_out),
        .DONE     (done),
        .DIV_ERR  (div_err),
        .COUNT_OUT(count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: tracks mode, divisor, shadow divisor and cycles elapsed
    // in the current period; the expected counter is derived from those.
    int m_mode;     // 0 idle, 1 run, 2 done
    int m_div;
    int m_pend;
    int m_el;
    bit m_pv, m_clk, m_tick, m_err, m_on;
    bit m_ld;
    int m_nd;

    initial m_on = 1'b0;

    always @(posedge clk) begin
        m_ld = div_load && (div_in != 0);
        m_nd = m_ld ? int'(div_in) : (m_pv ? m_pend : m_div);
        if (!rst_n) begin
            m_mode = 0; m_div = 25000; m_pv = 0; m_pend = 0; m_el = 0;
            m_clk = 0; m_tick = 0; m_err = 0;
        end else begin
            if (div_load && div_in == 0) m_err = 1;
            case (m_mode)
                0: begin
                    m_tick = 0; m_clk = 0; m_el = 0;
                    if (m_ld) m_div = int'(div_in);
                    if (en) m_mode = 1;
                end
                1: begin
                    if (!en) begin
                        m_div = m_nd; m_pv = 0; m_el = 0;
                        m_clk = 0; m_tick = 0; m_mode = 0;
                    end else if (m_el < m_div - 1) begin
                        m_el++; m_tick = 0;
                        if (m_ld) begin m_pend = int'(div_in); m_pv = 1; end
                    end else begin
                        m_tick = 1; m_clk = !m_clk;
                        m_div = m_nd; m_pv = 0; m_el = 0;
                        if (oneshot) m_mode = 2;
                    end
                end
                default: begin
                    m_tick = 0; m_el = 0;
                    if (m_ld) m_div = int'(div_in);
                    if (!en) begin m_mode = 0; m_clk = 0; end
                end
            endcase
        end
        m_on = 1'b1;
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("mdl_count", int'(count_out), m_div - 1 - m_el);
            chk("mdl_clk",   int'(clk_out),   int'(m_clk));
            chk("mdl_tick",  int'(tick_out),  int'(m_tick));
            chk("mdl_done",  int'(done),      (m_mode == 2) ? 1 : 0);
            chk("mdl_err",   int'(div_err),   int'(m_err));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycles (negedges) until TICK_OUT is seen high; a bound expiry counts as a failure.
    task automatic wait_tick(input int bound, output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!tick_out && n < bound);
        if (!tick_out) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_tick: no tick within %0d cycles", bound);
        end
    endtask

    task automatic load(input int v);
        div_load = 1'b1;
        div_in   = 16'(v);
        cyc(1);
        div_load = 1'b0;
    endtask

    int seq_cnt [6];
    int seq_tick[6];
    int a, g, nt;

    initial begin
        rst_n = 1'b0; en = 1'b0; oneshot = 1'b0; div_load = 1'b0; div_in = '0;
        cyc(2);
        rst_n = 1'b1;

        // Reset then idle
        chk("rst_count", int'(count_out), 24999);
        cyc(100);
        chk("idle_count", int'(count_out), 24999);
        chk("idle_clk",   int'(clk_out), 0);
        chk("idle_tick",  int'(tick_out), 0);
        chk("idle_done",  int'(done), 0);
        chk("idle_err",   int'(div_err), 0);

        // Periodic DIV=4
        load(4);
        chk("ld4_count", int'(count_out), 3);
        en = 1'b1;
        seq_cnt  = '{3, 2, 1, 0, 3, 2};
        seq_tick = '{0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("div4_seq_count", int'(count_out), seq_cnt[i]);
            chk("div4_seq_tick",  int'(tick_out),  seq_tick[i]);
        end
        wait_tick(20, a);
        chk("div4_to_next", a, 3);
        chk("div4_clk_lo", int'(clk_out), 0);
        wait_tick(20, g);
        chk("div4_gap", g, 4);
        chk("div4_clk_hi", int'(clk_out), 1);

        // Glitch-free reload: load 6 while COUNT_OUT=2
        cyc(1);
        chk("rl_count2", int'(count_out), 2);
        load(6);
        wait_tick(20, a);
        chk("rl_cur_period", a + 2, 4);
        chk("rl_count5", int'(count_out), 5);
        wait_tick(20, g);
        chk("rl_gap6", g, 6);
        chk("rl_err", int'(div_err), 0);

        // One-shot DIV=3
        en = 1'b0;
        cyc(1);
        load(3);
        oneshot = 1'b1; en = 1'b1;
        wait_tick(20, a);
        chk("os_first", a, 4);
        chk("os_clk", int'(clk_out), 1);
        chk("os_done", int'(done), 1);
        nt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            nt += int'(tick_out);
        end
        chk("os_no_more_ticks", nt, 0);
        chk("os_clk_held", int'(clk_out), 1);
        en = 1'b0;
        cyc(1);
        chk("os_idle_done", int'(done), 0);
        chk("os_idle_clk", int'(clk_out), 0);
        en = 1'b1;
        wait_tick(20, a);
        chk("os_rearm", a, 4);
        nt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            nt += int'(tick_out);
        end
        chk("os_rearm_single", nt, 0);
        en = 1'b0; oneshot = 1'b0;
        cyc(1);

        // Zero load is rejected and flagged
        load(0);
        chk("zero_err", int'(div_err), 1);
        chk("zero_count", int'(count_out), 2);

        // DIV=1: continuous tick, clock toggles every cycle
        load(1);
        en = 1'b1;
        cyc(1);
        chk("d1_e0_count", int'(count_out), 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("d1_tick", int'(tick_out), 1);
            chk("d1_clk", int'(clk_out), (i % 2 == 0) ? 1 : 0);
        end
        en = 1'b0;
        cyc(1);

        // Max divisor
        load(16'hFFFF);
        chk("max_count", int'(count_out), 16'hFFFE);
        en = 1'b1;
        cyc(1);
        chk("max_run_first", int'(count_out), 16'hFFFE);
        cyc(1);
        chk("max_run_dec", int'(count_out), 16'hFFFD);
        en = 1'b0;
        cyc(1);

        // Reset mid-run with a pending load
        load(4);
        en = 1'b1;
        cyc(1);
        load(7);
        cyc(1);
        chk("mr_count1", int'(count_out), 1);
        rst_n = 1'b0; en = 1'b0;
        cyc(1);
        chk("mr_count", int'(count_out), 24999);
        chk("mr_clk",   int'(clk_out), 0);
        chk("mr_tick",  int'(tick_out), 0);
        chk("mr_done",  int'(done), 0);
        chk("mr_err",   int'(div_err), 0);
        rst_n = 1'b1;
        cyc(1);
        en = 1'b1;
        wait_tick(30000, a);
        chk("mr_first_tick", a, 25001);
        chk("mr_no_pend", int'(count_out), 24999);
        en = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
